flash_read_arbiter: RTL and testbench
=====================================

Name: flash_read_arbiter

Overview:
- Shares the board's single 16-bit parallel Flash read port between two requesters:
  - client 0: ROM image loader;
  - client 1: auxiliary reader, e.g. BIOS/config fetch.
- Each client uses the existing toggle req/ack handshake. The Flash side uses the same toggle protocol, and its ack arrives from another clock domain.
- Round-robin arbitration, per-client address/data latching, and a timeout with recovery so that a stalled Flash controller cannot hang a client.

Parameters:
- TIMEOUT_CYC, 4096: iclk cycles to wait for the Flash ack before aborting a transaction (valid range 16..65535).
- ERR_DATA, 16'hFFFF: data word returned to a client on timeout.

Ports:
- iclk  in  1  system clock
- ireset  in  1  reset
- ic0_req  in  1  client 0 request toggle; pending when ic0_req != oc0_ack
- ic0_addr  in  23  client 0 word-aligned byte address; bit 0 is ignored and driven 0 downstream
- oc0_ack  out  1  client 0 ack toggle
- oc0_data  out  16  client 0 read data, valid when oc0_ack == ic0_req
- ic1_req, ic1_addr, oc1_ack, oc1_data: same as client 0, for client 1
- ofl_addr  out  23  Flash address
- ofl_req  out  1  Flash request toggle
- ifl_ack  in  1  Flash ack toggle, asynchronous; 2-FF synchronized internally to ack_s2
- ifl_data  in  16  Flash data, stable from the ack toggle until the next request
- obusy  out  1  high whenever the FSM is not in IDLE
- ogrant  out  1  client index of the current or last grant
- otimeout  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- One clock. Reset is synchronous and active-high (ireset sampled on iclk rising edge).
- Reset values:
  - ofl_req=0, ofl_addr=0
  - oc0_ack=0, oc1_ack=0
  - oc0_data=0, oc1_data=0
  - obusy=1, ogrant=1 (so client 0 wins the first tie), otimeout=0
  - FSM=INIT, timeout counter=0
- Reset asserted mid-transaction: the in-flight operation is abandoned; no client ack toggles during reset.
- INIT (2 cycles, lets the ack synchronizer settle), then:
  - ofl_req <= ack_s2;
  - oc0_ack <= ic0_req, oc1_ack <= ic1_req, i.e. requests pending across reset are dropped;
  - go to IDLE.
- IDLE:
  - pend0 = ic0_req^oc0_ack, pend1 = ic1_req^oc1_ack.
  - Only one pending: grant it. Both pending: grant the client != ogrant.
  - On grant: ogrant <= winner; ofl_addr <= {winner addr[22:1],1'b0}; go to ISSUE.
- ISSUE (1 cycle): ofl_req <= ~ofl_req; counter <= 0; go to WAIT.
- WAIT:
  - ack_s2 == ofl_req: go to CAPTURE.
  - Else if counter == TIMEOUT_CYC-1: go to ABORT.
  - Else counter increments.
- CAPTURE (1 cycle): oc{g}_data <= ifl_data; oc{g}_ack <= ~oc{g}_ack in the same cycle; go to IDLE.
- ABORT (1 cycle): oc{g}_data <= ERR_DATA; toggle oc{g}_ack; otimeout <= 1; go to RECOVER.
- RECOVER: wait indefinitely for ack_s2 == ofl_req, then go to IDLE. No new Flash request is issued while the late ack is outstanding.
- Best-case latency, client req toggle to ack toggle: 1 (IDLE) + 1 (ISSUE) + Flash round trip + 2 sync + 1 (CAPTURE).
- A client toggling req again before its ack is a protocol violation. It is treated as no request (pend = 0 after the double toggle).
- The address is latched at grant; client address changes after grant have no effect.
- The losing client stays pending and is served on the next IDLE, so there is no starvation. Max wait is one transaction.
- obusy is low only in IDLE.

Decomposition:
- Shared package flash_pkg:
  - state encoding constants INIT/IDLE/ISSUE/WAIT/CAPTURE/ABORT/RECOVER (3 bits);
  - FL_AW=23, FL_DW=16;
  - ERR_DATA default.
- One natural sub-module: toggle_sync (2-FF synchronizer, reset to 0). Reused for ifl_ack and later for other cross-domain toggles.

Test Plan:
- Single read: client 0 toggles req with addr 23'h000102. Flash model acks after 5 cycles with data 16'hA55A. Required: ofl_addr=23'h000102, ofl_req toggles once, oc0_ack matches ic0_req, oc0_data=16'hA55A.
- Simultaneous requests from reset: both clients pend, addr0=23'h10, addr1=23'h20. Required: client 0 served first, then client 1; ogrant sequence 0,1; no idle Flash request in between.
- Back-to-back contention: client 0 re-requests immediately after each ack while client 1 stays pending. Required: grants alternate 0,1,0,1, and client 1 completes within one client-0 transaction.
- Timeout: Flash model withholds ack. Required:
  - client ack toggles after exactly TIMEOUT_CYC cycles in WAIT, with data 16'hFFFF;
  - otimeout=1 and stays set;
  - a late ack returns the FSM to IDLE;
  - the next read succeeds normally.
- Reset mid-transaction: ireset for 1 cycle while in WAIT with client 1 pending. Required:
  - all outputs take reset values and the pending request is dropped (oc1_ack==ic1_req after INIT);
  - ofl_req realigns to ack_s2;
  - no spurious Flash request.
- Bit-0 masking: ic1_addr=23'h000003. Required: ofl_addr=23'h000002.

Source files
------------

// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared types and constants for the Flash read path
package flash_pkg;

    localparam int FL_AW = 23;
    localparam int FL_DW = 16;

    localparam logic [FL_DW-1:0] ERR_DATA_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_ABORT   = 3'd5,
        ST_RECOVER = 3'd6
    } state_t;

endpackage

// File: rtl/toggle_sync.sv
// rtl/toggle_sync.sv - two-flop synchronizer for a toggle crossing clock domains
module toggle_sync (
    input  logic iclk,
    input  logic ireset,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/flash_read_arbiter.sv
// rtl/flash_read_arbiter.sv - round-robin sharing of the Flash read port between two toggle clients
module flash_read_arbiter
    import flash_pkg::*;
#(
    parameter int                TIMEOUT_CYC = 4096,
    parameter logic [FL_DW-1:0]  ERR_DATA    = ERR_DATA_DEF
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic             ic0_req,
    input  logic [FL_AW-1:0] ic0_addr,
    output logic             oc0_ack,
    output logic [FL_DW-1:0] oc0_data,
    input  logic             ic1_req,
    input  logic [FL_AW-1:0] ic1_addr,
    output logic             oc1_ack,
    output logic [FL_DW-1:0] oc1_data,
    output logic [FL_AW-1:0] ofl_addr,
    output logic             ofl_req,
    input  logic             ifl_ack,
    input  logic [FL_DW-1:0] ifl_data,
    output logic             obusy,
    output logic             ogrant,
    output logic             otimeout
);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_init_cnt;
    logic [15:0]        r_cnt;
    logic               r_fl_req;
    logic [FL_AW-1:0]   r_fl_addr;
    logic               r_c0_ack;
    logic               r_c1_ack;
    logic [FL_DW-1:0]   r_c0_data;
    logic [FL_DW-1:0]   r_c1_data;
    logic               r_grant;
    logic               r_timeout;

    logic               w_ack_s2;
    logic               w_pend0;
    logic               w_pend1;
    logic               w_win;
    logic               w_acked;
    logic               w_expired;
    logic [FL_AW-1:0]   w_sel_addr;

    toggle_sync u_ack_sync (
        .iclk   (iclk),
        .ireset (ireset),
        .i_d    (ifl_ack),
        .o_q    (w_ack_s2)
    );

    assign w_pend0    = ic0_req ^ r_c0_ack;
    assign w_pend1    = ic1_req ^ r_c1_ack;
    // On a tie the client that did not hold the last grant wins.
    assign w_win      = (w_pend0 && w_pend1) ? ~r_grant : w_pend1;
    assign w_sel_addr = w_win ? ic1_addr : ic0_addr;
    assign w_acked    = (w_ack_s2 == r_fl_req);
    assign w_expired  = (r_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:    if (r_init_cnt == 2'd2) w_next = ST_IDLE;
            ST_IDLE:    if (w_pend0 || w_pend1) w_next = ST_ISSUE;
            ST_ISSUE:   w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_acked)        w_next = ST_CAPTURE;
                else if (w_expired) w_next = ST_ABORT;
            end
            ST_CAPTURE: w_next = ST_IDLE;
            ST_ABORT:   w_next = ST_RECOVER;
            ST_RECOVER: if (w_acked) w_next = ST_IDLE;
            default:    w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_init_cnt <= 2'd0;
            r_cnt      <= 16'd0;
            r_fl_req   <= 1'b0;
            r_fl_addr  <= '0;
            r_c0_ack   <= 1'b0;
            r_c1_ack   <= 1'b0;
            r_c0_data  <= '0;
            r_c1_data  <= '0;
            r_grant    <= 1'b1;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // Leave INIT only once ack_s2 holds a sample taken after reset.
                    if (r_init_cnt == 2'd2) begin
                        r_fl_req <= w_ack_s2;
                        r_c0_ack <= ic0_req;
                        r_c1_ack <= ic1_req;
                    end else begin
                        r_init_cnt <= r_init_cnt + 2'd1;
                    end
                end
                ST_IDLE: begin
                    if (w_pend0 || w_pend1) begin
                        r_grant   <= w_win;
                        r_fl_addr <= w_sel_addr & ~23'd1;
                    end
                end
                ST_ISSUE: begin
                    r_fl_req <= ~r_fl_req;
                    r_cnt    <= 16'd0;
                end
                ST_WAIT: begin
                    if (!w_acked && !w_expired) r_cnt <= r_cnt + 16'd1;
                end
                ST_CAPTURE: begin
                    if (r_grant) begin
                        r_c1_data <= ifl_data;
                        r_c1_ack  <= ~r_c1_ack;
                    end else begin
                        r_c0_data <= ifl_data;
                        r_c0_ack  <= ~r_c0_ack;
                    end
                end
                ST_ABORT: begin
                    r_timeout <= 1'b1;
                    if (r_grant) begin
                        r_c1_data <= ERR_DATA;
                        r_c1_ack  <= ~r_c1_ack;
                    end else begin
                        r_c0_data <= ERR_DATA;
                        r_c0_ack  <= ~r_c0_ack;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oc0_ack  = r_c0_ack;
    assign oc0_data = r_c0_data;
    assign oc1_ack  = r_c1_ack;
    assign oc1_data = r_c1_data;
    assign ofl_addr = r_fl_addr;
    assign ofl_req  = r_fl_req;
    assign obusy    = (r_state != ST_IDLE);
    assign ogrant   = r_grant;
    assign otimeout = r_timeout;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb/tb_flash_read_arbiter.sv - directed vector bench for flash_read_arbiter
module tb_flash_read_arbiter;
    import flash_pkg::*;

    localparam int TO = 32;

    logic        iclk = 1'b0;
    logic        ireset;
    logic        ic0_req, ic1_req;
    logic [22:0] ic0_addr, ic1_addr;
    logic        oc0_ack, oc1_ack;
    logic [15:0] oc0_data, oc1_data;
    logic [22:0] ofl_addr;
    logic        ofl_req;
    logic        ifl_ack;
    logic [15:0] ifl_data;
    logic        obusy, ogrant, otimeout;

    always #5 iclk = ~iclk;

    flash_read_arbiter #(.TIMEOUT_CYC(TO), .ERR_DATA(16'hFFFF)) dut (
        .iclk(iclk), .ireset(ireset),
        .ic0_req(ic0_req), .ic0_addr(ic0_addr), .oc0_ack(oc0_ack), .oc0_data(oc0_data),
        .ic1_req(ic1_req), .ic1_addr(ic1_addr), .oc1_ack(oc1_ack), .oc1_data(oc1_data),
        .ofl_addr(ofl_addr), .ofl_req(ofl_req), .ifl_ack(ifl_ack), .ifl_data(ifl_data),
        .obusy(obusy), .ogrant(ogrant), .otimeout(otimeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    function automatic logic [15:0] fl_word(input logic [22:0] a);
        return a[15:0] ^ 16'hA458;
    endfunction

    // Flash model: answers a request toggle after fl_delay cycles unless held.
    bit fl_hold  = 1'b0;
    bit fl_force = 1'b0;
    int fl_delay = 5;
    int fl_cnt   = 0;
    initial begin
        ifl_ack  = 1'b0;
        ifl_data = 16'h0;
        forever begin
            @(negedge iclk);
            if (fl_force) begin
                ifl_ack  = 1'b1;
                fl_force = 1'b0;
            end else if (ireset || fl_hold || ofl_req === ifl_ack) begin
                fl_cnt = 0;
            end else begin
                fl_cnt++;
                if (fl_cnt >= fl_delay) begin
                    ifl_data = fl_word(ofl_addr);
                    ifl_ack  = ofl_req;
                    fl_cnt   = 0;
                end
            end
        end
    end

    logic prev_req;
    int   tog = 0;
    logic gq[$];
    always @(negedge iclk) begin
        if (ireset) begin
            prev_req = ofl_req;
        end else if (ofl_req !== prev_req) begin
            gq.push_back(ogrant);
            tog++;
            prev_req = ofl_req;
        end
    end

    task automatic creq(input int c, input logic [22:0] a);
        if (c == 0) begin ic0_addr = a; ic0_req = ~oc0_ack; end
        else        begin ic1_addr = a; ic1_req = ~oc1_ack; end
    endtask

    task automatic wait_ack(input int c, input string nm, output int cyc);
        cyc = 0;
        while (((c == 0) ? (oc0_ack !== ic0_req) : (oc1_ack !== ic1_req)) && cyc < 1000) begin
            @(negedge iclk);
            cyc++;
        end
        if (cyc >= 1000) bound_fail(nm);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (obusy !== 1'b0 && k < 100) begin
            @(negedge iclk);
            k++;
        end
        if (k >= 100) bound_fail(nm);
    endtask

    task automatic wait_fl_toggle(input logic r0, input string nm);
        int k = 0;
        while (ofl_req === r0 && k < 100) begin
            @(negedge iclk);
            k++;
        end
        if (k >= 100) bound_fail(nm);
    endtask

    typedef struct {
        int          c;
        logic [22:0] addr;
        int          dly;
        logic [22:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vt[4];

    initial begin
        int   cyc, t0;
        logic r0;

        vt[0] = '{0, 23'h000102, 5, 23'h000102, 16'hA55A};
        vt[1] = '{1, 23'h000003, 3, 23'h000002, 16'hA45A};
        vt[2] = '{0, 23'h7FFFFF, 1, 23'h7FFFFE, 16'h5BA6};
        vt[3] = '{1, 23'h012345, 7, 23'h012344, 16'h871C};

        ireset = 1'b1;
        ic0_req = 1'b0; ic1_req = 1'b0;
        ic0_addr = '0;  ic1_addr = '0;
        repeat (2) @(negedge iclk);
        chk("rst ofl_req",  ofl_req,  0);
        chk("rst ofl_addr", ofl_addr, 0);
        chk("rst c0_ack",   oc0_ack,  0);
        chk("rst c1_ack",   oc1_ack,  0);
        chk("rst c0_data",  oc0_data, 0);
        chk("rst c1_data",  oc1_data, 0);
        chk("rst busy",     obusy,    1);
        chk("rst grant",    ogrant,   1);
        chk("rst timeout",  otimeout, 0);
        ireset = 1'b0;
        wait_idle("init idle");
        chk("init ofl_req", ofl_req, 0);

        // Simultaneous requests: client 0 first, then client 1, no extra Flash request.
        gq.delete();
        t0 = tog;
        creq(0, 23'h10);
        creq(1, 23'h20);
        wait_ack(0, "sim c0", cyc);
        chk("sim c1 still pending", oc1_ack ^ ic1_req, 1);
        chk("sim c0 data", oc0_data, 16'hA448);
        wait_ack(1, "sim c1", cyc);
        chk("sim c1 data", oc1_data, 16'hA478);
        repeat (2) @(negedge iclk);
        chk("sim req count", tog - t0, 2);
        chk("sim grant0", (gq.size() > 0) ? gq[0] : 1'bx, 0);
        chk("sim grant1", (gq.size() > 1) ? gq[1] : 1'bx, 1);

        for (int i = 0; i < 4; i++) begin
            fl_delay = vt[i].dly;
            t0 = tog;
            creq(vt[i].c, vt[i].addr);
            wait_ack(vt[i].c, $sformatf("vec%0d ack", i), cyc);
            repeat (2) @(negedge iclk);
            chk($sformatf("vec%0d addr", i), ofl_addr, vt[i].exp_addr);
            chk($sformatf("vec%0d data", i), (vt[i].c == 0) ? oc0_data : oc1_data, vt[i].exp_data);
            chk($sformatf("vec%0d ack", i), (vt[i].c == 0) ? (oc0_ack ^ ic0_req) : (oc1_ack ^ ic1_req), 0);
            chk($sformatf("vec%0d fl toggles", i), tog - t0, 1);
            chk($sformatf("vec%0d grant", i), ogrant, vt[i].c);
        end

        // Back-to-back contention.
        fl_delay = 4;
        gq.delete();
        creq(0, 23'h30);
        creq(1, 23'h40);
        wait_ack(0, "b2b c0 a", cyc);
        creq(0, 23'h31);
        wait_ack(1, "b2b c1 a", cyc);
        chk("b2b c1 wait bounded", cyc <= 12, 1);
        chk("b2b c1 data a", oc1_data, fl_word(23'h40));
        creq(1, 23'h41);
        wait_ack(0, "b2b c0 b", cyc);
        chk("b2b c0 data b", oc0_data, fl_word(23'h30));
        wait_ack(1, "b2b c1 b", cyc);
        chk("b2b c1 data b", oc1_data, fl_word(23'h40));
        repeat (2) @(negedge iclk);
        chk("b2b grant count", gq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b2b grant%0d", i), (gq.size() > i) ? gq[i] : 1'bx, i % 2);

        // Timeout with late ack and recovery.
        fl_hold = 1'b1;
        r0 = ofl_req;
        creq(0, 23'h50);
        wait_fl_toggle(r0, "to issue");
        r0 = ofl_req;
        cyc = 0;
        while (oc0_ack !== ic0_req && cyc < 1000) begin
            @(negedge iclk);
            cyc++;
        end
        chk("to ack latency", cyc, TO + 1);
        chk("to data", oc0_data, 16'hFFFF);
        chk("to flag", otimeout, 1);
        t0 = tog;
        creq(1, 23'h60);
        repeat (6) @(negedge iclk);
        chk("to recover busy", obusy, 1);
        chk("to no new req", ofl_req, r0);
        fl_hold = 1'b0;
        wait_ack(1, "to next read", cyc);
        chk("to next data", oc1_data, 16'hA438);
        chk("to next toggles", tog - t0, 1);
        chk("to flag sticky", otimeout, 1);

        // Reset during WAIT with client 1 pending.
        if (oc1_ack) begin
            creq(1, 23'h66);
            wait_ack(1, "pre rst read", cyc);
        end
        @(negedge iclk);
        fl_hold = 1'b1;
        r0 = ofl_req;
        creq(1, 23'h70);
        wait_fl_toggle(r0, "rst issue");
        repeat (3) @(negedge iclk);
        ireset   = 1'b1;
        fl_force = 1'b1;
        @(negedge iclk);
        chk("mid rst ofl_req", ofl_req,  0);
        chk("mid rst c1_ack",  oc1_ack,  0);
        chk("mid rst busy",    obusy,    1);
        chk("mid rst grant",   ogrant,   1);
        chk("mid rst timeout", otimeout, 0);
        ireset = 1'b0;
        wait_idle("mid rst idle");
        chk("post rst c1 dropped", oc1_ack, 1);
        chk("post rst c0 aligned", oc0_ack ^ ic0_req, 0);
        chk("post rst realign", ofl_req, 1);
        r0 = ofl_req;
        fl_hold = 1'b0;
        repeat (10) @(negedge iclk);
        chk("post rst no req", ofl_req, r0);
        chk("post rst idle", obusy, 0);
        fl_delay = 2;
        creq(0, 23'h80);
        wait_ack(0, "post rst read", cyc);
        chk("post rst data", oc0_data, 16'hA4D8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
